div_sqrt_round_mvp: RTL and testbench
=====================================

Name: div_sqrt_round_mvp

Overview:
- Registered normalize/round/pack stage directly downstream of the non-restoring div/sqrt iteration block.
- Consumes the Done pulse, the pre-normalised mantissa (57 b) and the pre-normalised biased exponent (13 b signed) produced by that block.
- Produces an IEEE-754 packed result (FP64/FP32/FP16/FP16ALT) with OF/UF/NX flags over a valid/ready handshake toward writeback.
- Two-register pipeline (normalise, then round/pack) with back-pressure and kill.

Parameters:
- C_MANT_W, 57, pre-normalised mantissa width (C_MANT_FP64+5).
- C_EXP_W, 13, pre-normalised exponent width, two's complement (C_EXP_FP64+2).
- C_RES_W, 64, packed result width.

Ports:
- Clk_CI  in  1  clock.
- Rst_RI  in  1  reset. One clock; reset is asynchronous and active-high.
- Kill_SI  in  1  flush both stages.
- Done_SI  in  1  upstream result valid; single-cycle pulse.
- Ready_SO  out  1  stage can accept Done_SI this cycle.
- Mant_prenorm_DI  in  57  unsigned mantissa; hidden bit at [55] or [56].
- Exp_prenorm_DI  in  13  signed biased exponent.
- Sign_DI  in  1  result sign.
- Format_sel_SI  in  2  00 FP32, 01 FP64, 10 FP16, 11 FP16ALT.
- Rm_SI  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; other codes behave as RNE.
- Out_valid_SO  out  1  result valid.
- Out_ready_SI  in  1  downstream accepts.
- Result_DO  out  64  packed result; narrower formats NaN-boxed (upper bits all ones).
- Flags_DO  out  3  {OF, UF, NX}.

Behaviour:
- Reset values:
  - Out_valid_SO=0, Result_DO=0, Flags_DO=0.
  - Internal S1/S2 valid bits = 0.
  - Ready_SO=1 one cycle after reset deasserts.
- Accept: when Done_SI && Ready_SO, inputs are latched into S1. Ready_SO = !S1_valid || advance.
- advance = !S2_valid || Out_ready_SI. S1 moves into S2 only on advance.
- Latency: accept at cycle N gives Out_valid_SO at N+2 when there is no back-pressure. Sustained throughput is 1 per cycle.
- Handshake:
  - Result_DO and Flags_DO stay stable while Out_valid_SO && !Out_ready_SI.
  - Transfer occurs on Out_valid_SO && Out_ready_SI.
- S1 normalise (registered):
  - If Mant[56]=1: shift right 1 (shifted-out bit goes to sticky) and add 1 to the exponent.
  - The hidden bit then sits at [55].
  - If exp ≤ 0 (subnormal): shift right by 1−exp, exp:=0. Shift amounts > F+2 collapse all bits into sticky.
  - F = 52/23/10/7 for FP64/FP32/FP16/FP16ALT.
  - Captured in S1: frac = bits [54:55−F], guard = bit [54−F], sticky = OR of all lower bits, plus tiny = (exp ≤ 0 before the shift).
- S2 round/pack (registered):
  - Increment condition per RM:
    - RNE: G&(S|lsb).
    - RTZ: 0.
    - RDN: sign&(G|S).
    - RUP: !sign&(G|S).
    - RMM: G.
  - Fraction carry-out increments the exponent; a subnormal rounding up into the smallest normal is handled naturally by this carry.
  - NX = G|S.
  - UF = tiny & NX (tininess detected before rounding).
  - Overflow when the final exp ≥ Emax (2047/255/31/255):
    - OF=NX=1.
    - Result is ±Inf for RNE/RMM, and for RUP(+) / RDN(−).
    - Otherwise result is ±max-finite.
  - Zero mantissa with exp ≤ 0 yields signed zero with flags 0.
- Kill_SI has priority: next cycle S1_valid=S2_valid=0 and Out_valid_SO=0. A Done_SI in the same cycle as Kill_SI is dropped.
- Simultaneous Out transfer and new accept with both stages full: S2←S1 and S1←input in the same cycle; no bubble and no loss.
- Reset mid-operation clears all valid bits immediately (asynchronous). Data registers need not be cleared, but Result_DO must read 0 while Out_valid_SO=0.

Decomposition:
- Package defs_div_sqrt_mvp gets:
  - format-select and rounding-mode enums;
  - per-format constants F, Emax, bias;
  - a struct for the S1 payload {sign, exp, frac, guard, sticky, tiny, fmt, rm}.
- One sub-module: round_pack_mvp, combinational rounding, overflow handling and NaN-box packing, used by S2.

Test Plan:
- FP32, Mant=1<<55, Exp=127, RNE, Out_ready=1 → Result 0xFFFFFFFF3F800000, Flags 000, Out_valid exactly 2 cycles after Done.
- FP64, Exp=1023, frac all ones, G=1, S=0, RNE → 0x4000000000000000, NX=1. Same input with RTZ → 0x3FFFFFFFFFFFFFFF, NX=1.
- FP16, Exp=31, Mant=1<<55, sign 0: RNE → 0x…7C00, OF=NX=1; RTZ → 0x…7BFF, OF=NX=1.
- FP32, Exp=0, Mant=1<<55 → 0x…00400000, flags 000. Exp=−30, RUP → 0x…00000001, UF=NX=1.
- Out_ready held 0, three back-to-back Done pulses → first two accepted, Ready_SO=0 on the third until Out_ready rises. Results then emerge in order with no loss.
- Kill_SI asserted with both stages full and a coincident Done → Out_valid=0 next cycle, no stale result appears afterwards, Ready_SO=1.

Source files
------------

// File: rtl/defs_div_sqrt_mvp.sv
// defs_div_sqrt_mvp: shared types and per-format constants for the div/sqrt round stage
package defs_div_sqrt_mvp;
  localparam int C_FRAC_MAX = 52;
  typedef enum logic [1:0] {FMT_FP32 = 2'b00, FMT_FP64 = 2'b01, FMT_FP16 = 2'b10, FMT_FP16ALT = 2'b11} fmt_e;
  typedef enum logic [2:0] {RM_RNE = 3'b000, RM_RTZ = 3'b001, RM_RDN = 3'b010, RM_RUP = 3'b011, RM_RMM = 3'b100} rm_e;
  typedef struct packed {
    logic                  sign;
    logic [13:0]           exp;
    logic [C_FRAC_MAX-1:0] frac;
    logic                  guard;
    logic                  sticky;
    logic                  tiny;
    fmt_e                  fmt;
    rm_e                   rm;
  } s1_t;
  function automatic logic [5:0] frac_w(fmt_e f);
    return f == FMT_FP64 ? 6'd52 : f == FMT_FP32 ? 6'd23 : f == FMT_FP16 ? 6'd10 : 6'd7;
  endfunction
  function automatic logic [10:0] emax(fmt_e f);
    return f == FMT_FP64 ? 11'd2047 : f == FMT_FP16 ? 11'd31 : 11'd255;
  endfunction
  function automatic logic [10:0] bias(fmt_e f);
    return f == FMT_FP64 ? 11'd1023 : f == FMT_FP16 ? 11'd15 : 11'd127;
  endfunction
endpackage

// File: rtl/round_pack_mvp.sv
// round_pack_mvp: rounding, overflow saturation and NaN-boxed packing of a normalised payload
module round_pack_mvp
  import defs_div_sqrt_mvp::*;
(
  input  s1_t         s,
  output logic [63:0] result,
  output logic [2:0]  flags
);
  logic [5:0]  fw;
  logic [10:0] em, exp_o;
  logic [51:0] fmask, frac_o;
  logic [52:0] sum;
  logic [13:0] exp_r;
  logic        gs, inc, carry, of, to_inf;
  always_comb begin
    fw     = frac_w(s.fmt);
    em     = emax(s.fmt);
    fmask  = (52'd1 << fw) - 52'd1;
    gs     = s.guard | s.sticky;
    inc    = s.rm == RM_RTZ ? 1'b0 :
             s.rm == RM_RDN ? s.sign & gs :
             s.rm == RM_RUP ? !s.sign & gs :
             s.rm == RM_RMM ? s.guard : s.guard & (s.sticky | s.frac[0]);
    sum    = {1'b0, s.frac} + {52'd0, inc};
    carry  = |(sum & (53'd1 << fw));
    exp_r  = s.exp + {13'd0, carry};
    of     = exp_r >= {3'd0, em};
    // directed modes toward zero saturate to max-finite instead of infinity
    to_inf = s.rm == RM_RTZ ? 1'b0 : s.rm == RM_RDN ? s.sign : s.rm == RM_RUP ? !s.sign : 1'b1;
    exp_o  = of ? (to_inf ? em : em - 11'd1) : exp_r[10:0];
    frac_o = of ? (to_inf ? 52'd0 : fmask) : sum[51:0] & fmask;
    flags  = {of, s.tiny & gs, gs | of};
    result = s.fmt == FMT_FP64 ? {s.sign, exp_o, frac_o} :
             s.fmt == FMT_FP32 ? {32'hFFFF_FFFF, s.sign, exp_o[7:0], frac_o[22:0]} :
             s.fmt == FMT_FP16 ? {48'hFFFF_FFFF_FFFF, s.sign, exp_o[4:0], frac_o[9:0]} :
                                 {48'hFFFF_FFFF_FFFF, s.sign, exp_o[7:0], frac_o[6:0]};
  end
endmodule

// File: rtl/div_sqrt_round_mvp.sv
// div_sqrt_round_mvp: two-register normalise then round/pack stage with valid/ready and kill
module div_sqrt_round_mvp
  import defs_div_sqrt_mvp::*;
#(
  parameter int C_MANT_W = 57,
  parameter int C_EXP_W  = 13,
  parameter int C_RES_W  = 64
) (
  input  logic                Clk_CI,
  input  logic                Rst_RI,
  input  logic                Kill_SI,
  input  logic                Done_SI,
  output logic                Ready_SO,
  input  logic [C_MANT_W-1:0] Mant_prenorm_DI,
  input  logic [C_EXP_W-1:0]  Exp_prenorm_DI,
  input  logic                Sign_DI,
  input  logic [1:0]          Format_sel_SI,
  input  logic [2:0]          Rm_SI,
  output logic                Out_valid_SO,
  input  logic                Out_ready_SI,
  output logic [C_RES_W-1:0]  Result_DO,
  output logic [2:0]          Flags_DO
);
  s1_t                nrm, s1_q;
  logic               s1_v, s2_v, adv, acc, tiny;
  logic [55:0]        m, hi, lo;
  logic signed [13:0] e, sh_full;
  logic [5:0]         sh, fw;
  logic [63:0]        res_d, res_q;
  logic [2:0]         flg_d, flg_q;
  assign adv          = !s2_v || Out_ready_SI;
  assign Ready_SO     = !s1_v || adv;
  assign acc          = Done_SI && Ready_SO && !Kill_SI;
  assign Out_valid_SO = s2_v;
  assign Result_DO    = s2_v ? res_q : '0;
  assign Flags_DO     = s2_v ? flg_q : '0;
  always_comb begin
    m          = Mant_prenorm_DI[56] ? Mant_prenorm_DI[56:1] : Mant_prenorm_DI[55:0];
    e          = {Exp_prenorm_DI[12], Exp_prenorm_DI} + {13'd0, Mant_prenorm_DI[56]};
    tiny       = e <= 14'sd0;
    sh_full    = 14'sd1 - e;
    // beyond 56 every bit is already below the guard position
    sh         = !tiny ? 6'd0 : sh_full > 14'sd56 ? 6'd56 : sh_full[5:0];
    {hi, lo}   = {m, 56'd0} >> sh;
    fw         = frac_w(fmt_e'(Format_sel_SI));
    nrm.sign   = Sign_DI;
    nrm.exp    = tiny ? 14'd0 : e;
    nrm.frac   = 52'((hi & {1'b0, {55{1'b1}}}) >> (6'd55 - fw));
    nrm.guard  = |(hi & (56'd1 << (6'd54 - fw)));
    nrm.sticky = (Mant_prenorm_DI[56] & Mant_prenorm_DI[0]) | (|lo) | |(hi & ((56'd1 << (6'd54 - fw)) - 56'd1));
    nrm.tiny   = tiny;
    nrm.fmt    = fmt_e'(Format_sel_SI);
    nrm.rm     = rm_e'(Rm_SI);
  end
  round_pack_mvp u_round_pack (.s(s1_q), .result(res_d), .flags(flg_d));
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else if (Kill_SI) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (adv) s2_v <= s1_v;
      s1_v <= acc ? 1'b1 : adv ? 1'b0 : s1_v;
    end
  end
  always_ff @(posedge Clk_CI) begin
    if (acc) s1_q <= nrm;
    if (adv) begin
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end
endmodule

// File: tb/tb_div_sqrt_round_mvp.sv
// tb_div_sqrt_round_mvp: directed vectors with hand-computed results for the round/pack stage
module tb_div_sqrt_round_mvp;
  logic        clk = 1'b0, rst = 1'b1, kill = 1'b0, done = 1'b0, ready, sign = 1'b0;
  logic [56:0] mant = '0;
  logic [12:0] exp_in = '0;
  logic [1:0]  fmt = '0;
  logic [2:0]  rm = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [63:0] result;
  logic [2:0]  flags;
  int          n_cmp = 0, n_err = 0;
  localparam logic [56:0] H = 57'd1 << 55;
  localparam logic [56:0] F64_ONES = {5'd0, 52'hF_FFFF_FFFF_FFFF} << 3;
  always #5 clk = ~clk;
  div_sqrt_round_mvp dut (
    .Clk_CI(clk), .Rst_RI(rst), .Kill_SI(kill), .Done_SI(done), .Ready_SO(ready),
    .Mant_prenorm_DI(mant), .Exp_prenorm_DI(exp_in), .Sign_DI(sign), .Format_sel_SI(fmt),
    .Rm_SI(rm), .Out_valid_SO(out_valid), .Out_ready_SI(out_ready), .Result_DO(result), .Flags_DO(flags)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp_v);
    end
  endtask
  task automatic set_in(input logic [1:0] f, input logic [2:0] r, input logic s, input logic [56:0] mv, input logic [12:0] ev);
    fmt = f; rm = r; sign = s; mant = mv; exp_in = ev;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_one(input string tag, input logic [1:0] f, input logic [2:0] r, input logic s,
                         input logic [56:0] mv, input logic [12:0] ev, input logic [63:0] er, input logic [2:0] ef);
    out_ready = 1'b1;
    set_in(f, r, s, mv, ev);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk({tag, "_early"}, {63'd0, out_valid}, 64'd0);
    tick();
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_flg"}, {61'd0, flags}, {61'd0, ef});
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_res", result, 64'd0);
    chk("rst_flg", {61'd0, flags}, 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_ready", {63'd0, ready}, 64'd1);
    run_one("fp32_one", 2'b00, 3'b000, 1'b0, H, 13'd127, 64'hFFFF_FFFF_3F80_0000, 3'b000);
    run_one("fp64_rne", 2'b01, 3'b000, 1'b0, H | F64_ONES | (57'd1 << 2), 13'd1023, 64'h4000_0000_0000_0000, 3'b001);
    run_one("fp64_rtz", 2'b01, 3'b001, 1'b0, H | F64_ONES | (57'd1 << 2), 13'd1023, 64'h3FFF_FFFF_FFFF_FFFF, 3'b001);
    run_one("fp16_of_rne", 2'b10, 3'b000, 1'b0, H, 13'd31, 64'hFFFF_FFFF_FFFF_7C00, 3'b101);
    run_one("fp16_of_rtz", 2'b10, 3'b001, 1'b0, H, 13'd31, 64'hFFFF_FFFF_FFFF_7BFF, 3'b101);
    run_one("fp32_sub", 2'b00, 3'b000, 1'b0, H, 13'd0, 64'hFFFF_FFFF_0040_0000, 3'b000);
    run_one("fp32_tiny_rup", 2'b00, 3'b011, 1'b0, H, 13'(-30), 64'hFFFF_FFFF_0000_0001, 3'b011);
    run_one("fp32_m56", 2'b00, 3'b000, 1'b0, 57'd1 << 56, 13'd126, 64'hFFFF_FFFF_3F80_0000, 3'b000);
    run_one("fp16_rdn_neg", 2'b10, 3'b010, 1'b1, H | 57'd1, 13'd15, 64'hFFFF_FFFF_FFFF_BC01, 3'b001);
    run_one("fp16_rtz_neg", 2'b10, 3'b001, 1'b1, H | 57'd1, 13'd15, 64'hFFFF_FFFF_FFFF_BC00, 3'b001);
    run_one("fp64_zero", 2'b01, 3'b000, 1'b1, 57'd0, 13'(-5), 64'h8000_0000_0000_0000, 3'b000);
    run_one("fp16alt_one", 2'b11, 3'b000, 1'b0, H, 13'd127, 64'hFFFF_FFFF_FFFF_3F80, 3'b000);
    run_one("fp32_rmm_tie", 2'b00, 3'b100, 1'b0, H | (57'd1 << 31), 13'd127, 64'hFFFF_FFFF_3F80_0001, 3'b001);
    run_one("fp32_rne_tie", 2'b00, 3'b000, 1'b0, H | (57'd1 << 31), 13'd127, 64'hFFFF_FFFF_3F80_0000, 3'b001);
    run_one("fp32_of_rdn", 2'b00, 3'b010, 1'b0, H, 13'd255, 64'hFFFF_FFFF_7F7F_FFFF, 3'b101);
    run_one("rm_other_rne", 2'b00, 3'b111, 1'b0, H | (57'd1 << 31) | 57'd1, 13'd127, 64'hFFFF_FFFF_3F80_0001, 3'b001);
    tick();
    chk("drain_idle", {63'd0, out_valid}, 64'd0);
    // back-pressure: three back-to-back requests against a stalled output
    out_ready = 1'b0;
    set_in(2'b00, 3'b000, 1'b0, H, 13'd127);
    done = 1'b1;
    tick();
    chk("bp_rdy_b", {63'd0, ready}, 64'd1);
    exp_in = 13'd128;
    tick();
    exp_in = 13'd129;
    chk("bp_rdy_c", {63'd0, ready}, 64'd0);
    chk("bp_valid_a", {63'd0, out_valid}, 64'd1);
    chk("bp_res_a", result, 64'hFFFF_FFFF_3F80_0000);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_hold_rdy", {63'd0, ready}, 64'd0);
      chk("bp_hold_res", result, 64'hFFFF_FFFF_3F80_0000);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_up", {63'd0, ready}, 64'd1);
    tick();
    done = 1'b0;
    chk("bp_valid_b", {63'd0, out_valid}, 64'd1);
    chk("bp_res_b", result, 64'hFFFF_FFFF_4000_0000);
    tick();
    chk("bp_valid_c", {63'd0, out_valid}, 64'd1);
    chk("bp_res_c", result, 64'hFFFF_FFFF_4080_0000);
    tick();
    chk("bp_empty", {63'd0, out_valid}, 64'd0);
    // kill with both stages full and a coincident request
    out_ready = 1'b0;
    set_in(2'b00, 3'b000, 1'b0, H, 13'd127);
    done = 1'b1;
    tick();
    tick();
    kill = 1'b1;
    exp_in = 13'd129;
    tick();
    kill = 1'b0;
    done = 1'b0;
    chk("kill_valid", {63'd0, out_valid}, 64'd0);
    chk("kill_ready", {63'd0, ready}, 64'd1);
    chk("kill_res", result, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("kill_no_stale", {63'd0, out_valid}, 64'd0);
    end
    run_one("post_kill", 2'b00, 3'b000, 1'b0, H, 13'd128, 64'hFFFF_FFFF_4000_0000, 3'b000);
    // asynchronous reset while a result is pending
    out_ready = 1'b0;
    set_in(2'b00, 3'b000, 1'b0, H, 13'd127);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_res", result, 64'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("after_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("after_rst_ready", {63'd0, ready}, 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
